// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with a valid/ready byte output.
// Optional even-parity frames (8E1) when UART_RX_PARITY_EN is defined.
//
// Parameters:
//   CLK_FREQ  clk frequency in Hz
//   BAUD      line bit rate in bit/s
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-low reset
//   rx_i          asynchronous serial line, idle high
//   ready_i       consumer accepts data_o
//   parity_err_o  one-cycle pulse on a parity mismatch (UART_RX_PARITY_EN only)
//   data_o        received byte
//   valid_o       data_o holds an unconsumed byte
//   frame_err_o   one-cycle pulse on a bad stop bit
//   overrun_o     one-cycle pulse when a completed byte is dropped
module uart_receiver #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  input  logic       ready_i,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  // Registers
  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
`endif

  // Next-state / strobe wires
  logic             w_rx;
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_bit_next;
  logic [7:0]       w_shift_next;
  logic             w_done;
  logic             w_ferr;
`ifdef UART_RX_PARITY_EN
  logic             w_par_next;
  logic             w_perr;
`endif
  logic             w_hs;
  logic             w_load;
  logic             w_ovr;
  logic             w_valid_next;

  assign w_rx = r_sync2;

  // Next-state, bit timing and frame decode
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_done       = 1'b0;
    w_ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_next   = r_par;
    w_perr       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        w_bit_next = 3'd0;
        if (!w_rx) w_state_next = START;
      end
      START: begin
        // Mid-start-bit check: a high sample here was only a glitch
        if (r_cnt == CNT_HALF_M1) begin
          w_cnt_next   = '0;
          w_state_next = w_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rx, r_shift[7:1]};
          w_bit_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_par_next   = w_rx;
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
          w_ferr       = !w_rx;
`ifdef UART_RX_PARITY_EN
          // Even parity: data bits plus parity bit must XOR to zero
          w_perr       = ^{r_shift, r_par};
          w_done       = w_rx && !(^{r_shift, r_par});
`else
          w_done       = w_rx;
`endif
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase

    // Output handshake: a completing handshake frees the slot for a new byte
    w_hs         = valid_o && ready_i;
    w_load       = w_done && (!valid_o || w_hs);
    w_ovr        = w_done && valid_o && !w_hs;
    w_valid_next = valid_o;
    if (w_load)    w_valid_next = 1'b1;
    else if (w_hs) w_valid_next = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      r_sync1      <= rx_i;
      r_sync2      <= r_sync1;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit_idx    <= w_bit_next;
      r_shift      <= w_shift_next;
      if (w_load) data_o <= r_shift;
      valid_o      <= w_valid_next;
      frame_err_o  <= w_ferr;
      overrun_o    <= w_ovr;
`ifdef UART_RX_PARITY_EN
      r_par        <= w_par_next;
      parity_err_o <= w_perr;
`endif
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver at CLKS_PER_BIT=16.
module tb_uart_receiver;

  localparam int unsigned C = 16;

  logic       clk;
  logic       reset;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Event counters sampled on the falling edge
  int         mon_valid = 0;
  int         mon_hs    = 0;
  int         mon_ferr  = 0;
  int         mon_ovr   = 0;
  int         mon_perr  = 0;
  logic [7:0] mon_hs_data = 8'h00;

  uart_receiver #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .ready_i     (ready_i),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (valid_o) mon_valid <= mon_valid + 1;
      if (valid_o && ready_i) begin
        mon_hs      <= mon_hs + 1;
        mon_hs_data <= data_o;
      end
      if (frame_err_o) mon_ferr <= mon_ferr + 1;
      if (overrun_o)   mon_ovr  <= mon_ovr + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) mon_perr <= mon_perr + 1;
`endif
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n line bits LSB first, then return to idle
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_bit(bits[i]);
    idle(24);
  endtask

  // One frame with correct parity (when configured) and the given stop level
  task automatic send_byte(input logic [7:0] b, input logic stop_b);
`ifdef UART_RX_PARITY_EN
    send_bits({stop_b, ^b, b, 1'b0}, 11);
`else
    send_bits({1'b0, stop_b, b, 1'b0}, 10);
`endif
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (data_o !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_o); else n_pass++;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o); else n_pass++;
    n_total++;
    if (frame_err_o !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err_o); else n_pass++;
    n_total++;
    if (overrun_o !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", overrun_o); else n_pass++;
    reset = 1'b1;
    idle(4);
  endtask

  task automatic test_basic;
    int v0, h0, f0, o0;
    ready_i = 1'b1;
    v0 = mon_valid; h0 = mon_hs; f0 = mon_ferr; o0 = mon_ovr;
    send_byte(8'hA5, 1'b1);
    n_total++;
    if (data_o !== 8'hA5) $display("FAIL basic_data: got %h expected a5", data_o); else n_pass++;
    n_total++;
    if (mon_valid - v0 != 1) $display("FAIL basic_valid_cycles: got %0d expected 1", mon_valid - v0); else n_pass++;
    n_total++;
    if (mon_hs - h0 != 1 || mon_hs_data !== 8'hA5)
      $display("FAIL basic_handshake: got %0d/%h expected 1/a5", mon_hs - h0, mon_hs_data);
    else n_pass++;
    n_total++;
    if (mon_ferr != f0 || mon_ovr != o0)
      $display("FAIL basic_flags: got ferr %0d ovr %0d expected 0 0", mon_ferr - f0, mon_ovr - o0);
    else n_pass++;
  endtask

  task automatic test_overrun;
    int h0, o0;
    ready_i = 1'b0;
    h0 = mon_hs; o0 = mon_ovr;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h81, 1'b1);
    n_total++;
    if (data_o !== 8'h3C) $display("FAIL ovr_data_held: got %h expected 3c", data_o); else n_pass++;
    n_total++;
    if (valid_o !== 1'b1) $display("FAIL ovr_valid_held: got %b expected 1", valid_o); else n_pass++;
    n_total++;
    if (mon_ovr - o0 != 1) $display("FAIL ovr_pulses: got %0d expected 1", mon_ovr - o0); else n_pass++;
    n_total++;
    if (mon_hs != h0) $display("FAIL ovr_no_handshake: got %0d expected 0", mon_hs - h0); else n_pass++;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (mon_hs - h0 != 1 || mon_hs_data !== 8'h3C)
      $display("FAIL ovr_handshake: got %0d/%h expected 1/3c", mon_hs - h0, mon_hs_data);
    else n_pass++;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL ovr_valid_drop: got %b expected 0", valid_o); else n_pass++;
  endtask

  task automatic test_frame_err;
    int v0, h0, f0;
    ready_i = 1'b1;
    v0 = mon_valid; h0 = mon_hs; f0 = mon_ferr;
    send_byte(8'h55, 1'b0);
    n_total++;
    if (mon_ferr - f0 != 1) $display("FAIL ferr_pulses: got %0d expected 1", mon_ferr - f0); else n_pass++;
    n_total++;
    if (mon_valid != v0) $display("FAIL ferr_no_valid: got %0d expected 0", mon_valid - v0); else n_pass++;
    send_byte(8'h0F, 1'b1);
    n_total++;
    if (mon_hs - h0 != 1 || mon_hs_data !== 8'h0F)
      $display("FAIL ferr_next_frame: got %0d/%h expected 1/0f", mon_hs - h0, mon_hs_data);
    else n_pass++;
    n_total++;
    if (mon_ferr - f0 != 1) $display("FAIL ferr_next_clean: got %0d expected 1", mon_ferr - f0); else n_pass++;
  endtask

  task automatic test_glitch;
    int v0, f0, o0, p0;
    v0 = mon_valid; f0 = mon_ferr; o0 = mon_ovr; p0 = mon_perr;
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(12 * C);
    n_total++;
    if (mon_valid != v0) $display("FAIL glitch_valid: got %0d expected 0", mon_valid - v0); else n_pass++;
    n_total++;
    if (mon_ferr != f0) $display("FAIL glitch_ferr: got %0d expected 0", mon_ferr - f0); else n_pass++;
    n_total++;
    if (mon_ovr != o0 || mon_perr != p0)
      $display("FAIL glitch_flags: got ovr %0d perr %0d expected 0 0", mon_ovr - o0, mon_perr - p0);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int v0, h0, f0;
    v0 = mon_valid; h0 = mon_hs; f0 = mon_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid_o); else n_pass++;
    reset = 1'b1;
    idle(8 * C);
    send_byte(8'h12, 1'b1);
    n_total++;
    if (mon_hs - h0 != 1 || mon_hs_data !== 8'h12)
      $display("FAIL rstmid_delivery: got %0d/%h expected 1/12", mon_hs - h0, mon_hs_data);
    else n_pass++;
    n_total++;
    if (mon_valid - v0 != 1) $display("FAIL rstmid_valid_cycles: got %0d expected 1", mon_valid - v0); else n_pass++;
    n_total++;
    if (mon_ferr != f0) $display("FAIL rstmid_ferr: got %0d expected 0", mon_ferr - f0); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, h0, p0;
    ready_i = 1'b1;
    v0 = mon_valid; h0 = mon_hs; p0 = mon_perr;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    n_total++;
    if (mon_perr - p0 != 1) $display("FAIL par_err_pulse: got %0d expected 1", mon_perr - p0); else n_pass++;
    n_total++;
    if (mon_valid != v0) $display("FAIL par_err_no_valid: got %0d expected 0", mon_valid - v0); else n_pass++;
    send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    n_total++;
    if (mon_hs - h0 != 1 || mon_hs_data !== 8'h07)
      $display("FAIL par_ok_data: got %0d/%h expected 1/07", mon_hs - h0, mon_hs_data);
    else n_pass++;
    n_total++;
    if (mon_perr - p0 != 1) $display("FAIL par_ok_no_err: got %0d expected 1", mon_perr - p0); else n_pass++;
  endtask
`endif

  initial begin
    rx_i    = 1'b1;
    ready_i = 1'b0;
    reset   = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
